// File: rtl/mem_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// mem_cmd_scheduler
//
// In-order DRAM command scheduler for a single-rank model with an open-page
// policy. Parsed trace requests are queued in a small FIFO and served one at a
// time. For each request the scheduler issues PRE/ACT/RD/WR commands with
// tRP/tRCD/tCL/burst spacing, and reports completion with a done pulse.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    FIFO can accept a request (not full)
//   req_op_i       0=read, 1=write, 2=ifetch, 3=reserved (served as read)
//   req_addr_i     byte address
//   cmd_valid_o    one-cycle command strobe
//   cmd_type_o     0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE
//   cmd_bank_o     target bank
//   cmd_row_o      row (meaningful for ACT)
//   cmd_col_o      column (meaningful for RD/WR)
//   done_valid_o   one-cycle completion pulse
//   done_op_o      op of the completed request
//   done_addr_o    address of the completed request
//   busy_o         FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module mem_cmd_scheduler #(
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 8,
   parameter int COL_LSB  = 3,
   parameter int COL_W    = 7,
   parameter int BANK_LSB = 10,
   parameter int BANK_W   = 2,
   parameter int ROW_LSB  = 12,
   parameter int T_RCD    = 3,
   parameter int T_RP     = 3,
   parameter int T_CL     = 4,
   parameter int T_BURST  = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [1:0]                req_op_i,
   input  logic [ADDR_W-1:0]         req_addr_i,
   output logic                      cmd_valid_o,
   output logic [2:0]                cmd_type_o,
   output logic [BANK_W-1:0]         cmd_bank_o,
   output logic [ADDR_W-ROW_LSB-1:0] cmd_row_o,
   output logic [COL_W-1:0]          cmd_col_o,
   output logic                      done_valid_o,
   output logic [1:0]                done_op_o,
   output logic [ADDR_W-1:0]         done_addr_o,
   output logic                      busy_o
);

   localparam int ROW_W   = ADDR_W - ROW_LSB;
   localparam int NBANK   = 1 << BANK_W;
   localparam int PW      = $clog2(DEPTH);
   localparam int CW      = PW + 1;
   localparam int CNT_W   = 8;
   localparam int RWW_CYC = T_CL + T_BURST - 1;

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_ACT = 3'd1;
   localparam logic [2:0] CMD_RD  = 3'd2;
   localparam logic [2:0] CMD_WR  = 3'd3;
   localparam logic [2:0] CMD_PRE = 3'd4;

   localparam logic [1:0] OP_WRITE = 2'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_PRE_W,
      S_ACT,
      S_ACT_W,
      S_RW,
      S_RW_W
   } state_t;

   // Request FIFO storage and pointers
   logic [1:0]        fifo_op_q   [DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   // Scheduler state
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        cur_op_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [NBANK-1:0]  bank_open_q;
   logic [ROW_W-1:0]  bank_row_q [NBANK];

   // Registered outputs
   logic              cmd_valid_q;
   logic [2:0]        cmd_type_q;
   logic [BANK_W-1:0] cmd_bank_q;
   logic [ROW_W-1:0]  cmd_row_q;
   logic [COL_W-1:0]  cmd_col_q;
   logic              done_valid_q;
   logic [1:0]        done_op_q;
   logic [ADDR_W-1:0] done_addr_q;

   // Address decode of the FIFO head and of the request in service
   logic [1:0]        head_op;
   logic [ADDR_W-1:0] head_addr;
   logic [BANK_W-1:0] head_bank;
   logic [ROW_W-1:0]  head_row;
   logic [COL_W-1:0]  head_col;
   logic              head_open;
   logic              head_hit;
   logic [BANK_W-1:0] cur_bank;
   logic [ROW_W-1:0]  cur_row;

   assign fifo_full   = (count_q == CW'(DEPTH));
   assign fifo_empty  = (count_q == '0);
   // Ready depends only on fullness, so a pop in the same cycle does not open
   // a slot until the following cycle.
   assign req_ready_o = !fifo_full;
   assign fifo_push   = req_valid_i && !fifo_full;
   assign fifo_pop    = (state_q == S_IDLE) && !fifo_empty;

   assign head_op   = fifo_op_q[rd_ptr_q];
   assign head_addr = fifo_addr_q[rd_ptr_q];
   assign head_bank = head_addr[BANK_LSB +: BANK_W];
   assign head_row  = head_addr[ROW_LSB +: ROW_W];
   assign head_col  = head_addr[COL_LSB +: COL_W];
   assign head_open = bank_open_q[head_bank];
   assign head_hit  = (bank_row_q[head_bank] == head_row);
   assign cur_bank  = cur_addr_q[BANK_LSB +: BANK_W];
   assign cur_row   = cur_addr_q[ROW_LSB +: ROW_W];

   // FIFO pointer/count next-state; pointers wrap naturally since DEPTH is a
   // power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (fifo_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({fifo_push, fifo_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO bookkeeping registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO payload storage needs no reset; entries are only read once written
   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_op_q[wr_ptr_q]   <= req_op_i;
         fifo_addr_q[wr_ptr_q] <= req_addr_i;
      end
   end

   // Command sequencer. Command and done outputs are registered and set on
   // the edge that enters the state they belong to, so they line up exactly
   // with the state they describe. Wait counters load (cycles - 2) because
   // the first wait cycle is the one following the command cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_op_q     <= '0;
         cur_addr_q   <= '0;
         bank_open_q  <= '0;
         for (int b = 0; b < NBANK; b++) begin
            bank_row_q[b] <= '0;
         end
         cmd_valid_q  <= 1'b0;
         cmd_type_q   <= CMD_NOP;
         cmd_bank_q   <= '0;
         cmd_row_q    <= '0;
         cmd_col_q    <= '0;
         done_valid_q <= 1'b0;
         done_op_q    <= '0;
         done_addr_q  <= '0;
      end else begin
         cmd_valid_q  <= 1'b0;
         cmd_type_q   <= CMD_NOP;
         done_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fifo_pop) begin
                  cur_op_q    <= head_op;
                  cur_addr_q  <= head_addr;
                  cmd_valid_q <= 1'b1;
                  cmd_bank_q  <= head_bank;
                  cmd_row_q   <= head_row;
                  cmd_col_q   <= head_col;
                  if (head_open && head_hit) begin
                     state_q    <= S_RW;
                     cmd_type_q <= (head_op == OP_WRITE) ? CMD_WR : CMD_RD;
                  end else if (head_open) begin
                     state_q    <= S_PRE;
                     cmd_type_q <= CMD_PRE;
                  end else begin
                     state_q    <= S_ACT;
                     cmd_type_q <= CMD_ACT;
                  end
               end
            end
            S_PRE: begin
               bank_open_q[cur_bank] <= 1'b0;
               if (T_RP == 1) begin
                  state_q     <= S_ACT;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= CMD_ACT;
               end else begin
                  state_q <= S_PRE_W;
                  cnt_q   <= CNT_W'(T_RP - 2);
               end
            end
            S_PRE_W: begin
               if (cnt_q == '0) begin
                  state_q     <= S_ACT;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= CMD_ACT;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_ACT: begin
               bank_open_q[cur_bank] <= 1'b1;
               bank_row_q[cur_bank]  <= cur_row;
               if (T_RCD == 1) begin
                  state_q     <= S_RW;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= (cur_op_q == OP_WRITE) ? CMD_WR : CMD_RD;
               end else begin
                  state_q <= S_ACT_W;
                  cnt_q   <= CNT_W'(T_RCD - 2);
               end
            end
            S_ACT_W: begin
               if (cnt_q == '0) begin
                  state_q     <= S_RW;
                  cmd_valid_q <= 1'b1;
                  cmd_type_q  <= (cur_op_q == OP_WRITE) ? CMD_WR : CMD_RD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_RW: begin
               // Data phase always spans at least one wait cycle; done is
               // raised for the last of those cycles.
               state_q <= S_RW_W;
               cnt_q   <= CNT_W'(RWW_CYC - 1);
               if (RWW_CYC == 1) begin
                  done_valid_q <= 1'b1;
                  done_op_q    <= cur_op_q;
                  done_addr_q  <= cur_addr_q;
               end
            end
            S_RW_W: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     done_valid_q <= 1'b1;
                     done_op_q    <= cur_op_q;
                     done_addr_q  <= cur_addr_q;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_valid_o  = cmd_valid_q;
   assign cmd_type_o   = cmd_type_q;
   assign cmd_bank_o   = cmd_bank_q;
   assign cmd_row_o    = cmd_row_q;
   assign cmd_col_o    = cmd_col_q;
   assign done_valid_o = done_valid_q;
   assign done_op_o    = done_op_q;
   assign done_addr_o  = done_addr_q;
   assign busy_o       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mem_cmd_scheduler
//
// Directed bench for mem_cmd_scheduler. Single requests from a vector table
// exercise miss/hit/conflict paths with exact command timing; hand-written
// sequences cover FIFO back-pressure and reset during service.
// ---------------------------------------------------------------------------
module tb_mem_cmd_scheduler;

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_ACT = 3'd1;
   localparam logic [2:0] CMD_RD  = 3'd2;
   localparam logic [2:0] CMD_WR  = 3'd3;
   localparam logic [2:0] CMD_PRE = 3'd4;

   localparam int KIND_MISS = 0;
   localparam int KIND_HIT  = 1;
   localparam int KIND_CONF = 2;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      int          kind;
      logic [1:0]  bank;
      logic [19:0] row;
      logic [6:0]  col;
   } vecT;

   typedef struct {
      int          cyc;
      logic [2:0]  typ;
      logic [1:0]  bank;
      logic [19:0] row;
      logic [6:0]  col;
   } cmdRecT;

   typedef struct {
      int          cyc;
      logic [1:0]  op;
      logic [31:0] addr;
   } doneRecT;

   logic        clk;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic [1:0]  reqOp;
   logic [31:0] reqAddr;
   logic        cmdValid;
   logic [2:0]  cmdType;
   logic [1:0]  cmdBank;
   logic [19:0] cmdRow;
   logic [6:0]  cmdCol;
   logic        doneValid;
   logic [1:0]  doneOp;
   logic [31:0] doneAddr;
   logic        busy;

   int      cyc = 0;
   int      checks = 0;
   int      errors = 0;
   vecT     vecs[9];
   cmdRecT  cmdQ[$];
   doneRecT doneQ[$];

   mem_cmd_scheduler dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_op_i     (reqOp),
      .req_addr_i   (reqAddr),
      .cmd_valid_o  (cmdValid),
      .cmd_type_o   (cmdType),
      .cmd_bank_o   (cmdBank),
      .cmd_row_o    (cmdRow),
      .cmd_col_o    (cmdCol),
      .done_valid_o (doneValid),
      .done_op_o    (doneOp),
      .done_addr_o  (doneAddr),
      .busy_o       (busy)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: the cycle following rising edge n has cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   // Log every command strobe and done pulse mid-cycle
   always @(negedge clk) begin
      if (rstN) begin
         if (cmdValid) cmdQ.push_back('{cyc, cmdType, cmdBank, cmdRow, cmdCol});
         if (doneValid) doneQ.push_back('{cyc, doneOp, doneAddr});
      end
   end

   // Safety net against a hung design
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, "_cmd_valid"}, cmdValid, 0);
      chk({tag, "_cmd_type"}, cmdType, 0);
      chk({tag, "_cmd_bank"}, cmdBank, 0);
      chk({tag, "_cmd_row"}, cmdRow, 0);
      chk({tag, "_cmd_col"}, cmdCol, 0);
      chk({tag, "_done_valid"}, doneValid, 0);
      chk({tag, "_done_op"}, doneOp, 0);
      chk({tag, "_done_addr"}, doneAddr, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_req_ready"}, reqReady, 1);
   endtask

   task automatic waitIdle();
      int w = 0;
      @(posedge clk); #1;
      while (busy && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      chk("wait_idle_busy", busy, 0);
   endtask

   // Present one request and hold it until it is taken; returns the edge index
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, output int acceptCyc);
      int w = 0;
      @(posedge clk); #1;
      reqValid = 1'b1;
      reqOp    = op;
      reqAddr  = addr;
      while (!reqReady && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("req_ready_before_push", reqReady, 1);
      @(posedge clk); #1;
      acceptCyc = cyc;
      reqValid  = 1'b0;
   endtask

   // Expected command train per access kind, counted from the first command
   task automatic checkOutput(input vecT v, input int acceptCyc, input int idx);
      int         base = acceptCyc + 1;
      int         n;
      int         doneOff;
      int         expOff[3];
      logic [2:0] expTyp[3];
      logic [2:0] rwTyp;
      int         w = 0;
      rwTyp = (v.op == 2'd1) ? CMD_WR : CMD_RD;
      case (v.kind)
         KIND_HIT: begin
            n = 1; doneOff = 5;
            expTyp[0] = rwTyp;   expOff[0] = 0;
         end
         KIND_CONF: begin
            n = 3; doneOff = 11;
            expTyp[0] = CMD_PRE; expOff[0] = 0;
            expTyp[1] = CMD_ACT; expOff[1] = 3;
            expTyp[2] = rwTyp;   expOff[2] = 6;
         end
         default: begin
            n = 2; doneOff = 8;
            expTyp[0] = CMD_ACT; expOff[0] = 0;
            expTyp[1] = rwTyp;   expOff[1] = 3;
         end
      endcase
      while (doneQ.size() == 0 && w < 60) begin
         @(negedge clk); #1;
         w++;
      end
      chk($sformatf("v%0d_done_count", idx), doneQ.size(), 1);
      chk($sformatf("v%0d_cmd_count", idx), cmdQ.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < cmdQ.size()) begin
            chk($sformatf("v%0d_cmd%0d_cycle", idx, i), cmdQ[i].cyc, base + expOff[i]);
            chk($sformatf("v%0d_cmd%0d_type", idx, i), cmdQ[i].typ, expTyp[i]);
            chk($sformatf("v%0d_cmd%0d_bank", idx, i), cmdQ[i].bank, v.bank);
            if (expTyp[i] == CMD_ACT) chk($sformatf("v%0d_cmd%0d_row", idx, i), cmdQ[i].row, v.row);
            if (expTyp[i] == rwTyp) chk($sformatf("v%0d_cmd%0d_col", idx, i), cmdQ[i].col, v.col);
         end
      end
      if (doneQ.size() > 0) begin
         chk($sformatf("v%0d_done_cycle", idx), doneQ[0].cyc, base + doneOff);
         chk($sformatf("v%0d_done_op", idx), doneQ[0].op, v.op);
         chk($sformatf("v%0d_done_addr", idx), doneQ[0].addr, v.addr);
         chk($sformatf("v%0d_busy_at_done", idx), busy, 1);
         @(negedge clk); #1;
         chk($sformatf("v%0d_busy_after_done", idx), busy, 0);
      end
   endtask

   initial begin
      int     acc;
      int     accepted;
      int     firstStall;
      int     firstAcc;
      int     w;
      logic   readyNow;

      rstN     = 1'b0;
      reqValid = 1'b0;
      reqOp    = 2'd0;
      reqAddr  = 32'd0;

      //         op     addr           kind       bank  row       col
      vecs[0] = '{2'd0, 32'h0001_0400, KIND_MISS, 2'd1, 20'h010, 7'd0};
      vecs[1] = '{2'd1, 32'h0001_0408, KIND_HIT,  2'd1, 20'h010, 7'd1};
      vecs[2] = '{2'd0, 32'h0002_0400, KIND_CONF, 2'd1, 20'h020, 7'd0};
      vecs[3] = '{2'd2, 32'h0000_0000, KIND_MISS, 2'd0, 20'h000, 7'd0};
      vecs[4] = '{2'd3, 32'h0000_0C10, KIND_MISS, 2'd3, 20'h000, 7'd2};
      vecs[5] = '{2'd0, 32'h0000_0800, KIND_MISS, 2'd2, 20'h000, 7'd0};
      vecs[6] = '{2'd0, 32'h0000_0818, KIND_HIT,  2'd2, 20'h000, 7'd3};
      vecs[7] = '{2'd1, 32'h0000_0020, KIND_HIT,  2'd0, 20'h000, 7'd4};
      vecs[8] = '{2'd0, 32'h0002_0400, KIND_MISS, 2'd1, 20'h020, 7'd0};

      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      @(negedge clk);
      rstN = 1'b1;

      for (int i = 0; i < 8; i++) begin
         waitIdle();
         cmdQ.delete();
         doneQ.delete();
         applyStimulus(vecs[i].op, vecs[i].addr, acc);
         checkOutput(vecs[i], acc, i);
      end

      // Twelve back-to-back reads: first one conflicts in bank 3, so the
      // FIFO fills while it is being served.
      waitIdle();
      cmdQ.delete();
      doneQ.delete();
      accepted   = 0;
      firstStall = -1;
      @(posedge clk); #1;
      reqValid = 1'b1;
      reqOp    = 2'd0;
      reqAddr  = 32'h0005_5C00;
      for (int c = 0; c < 400 && accepted < 12; c++) begin
         readyNow = reqReady;
         if (!readyNow && firstStall < 0) firstStall = accepted;
         @(posedge clk); #1;
         if (readyNow) begin
            accepted++;
            reqAddr = 32'h0005_5C00 + 32'(accepted * 8);
         end
      end
      reqValid = 1'b0;
      chk("b2b_accepts_before_stall", firstStall, 9);
      chk("b2b_total_accepted", accepted, 12);
      w = 0;
      while (doneQ.size() < 12 && w < 300) begin
         @(negedge clk); #1;
         w++;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("b2b_done_count", doneQ.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < doneQ.size()) begin
            chk($sformatf("b2b_done%0d_addr", i), doneQ[i].addr, 32'h0005_5C00 + 32'(i * 8));
            chk($sformatf("b2b_done%0d_op", i), doneQ[i].op, 0);
         end
      end

      // Reset while in ACT_W with three more requests queued
      waitIdle();
      cmdQ.delete();
      doneQ.delete();
      accepted = 0;
      firstAcc = -1;
      @(posedge clk); #1;
      reqValid = 1'b1;
      reqOp    = 2'd0;
      reqAddr  = 32'h0007_7400;
      for (int c = 0; c < 20 && accepted < 4; c++) begin
         readyNow = reqReady;
         @(posedge clk); #1;
         if (readyNow) begin
            if (accepted == 0) firstAcc = cyc;
            accepted++;
            reqAddr = 32'h0007_7400 + 32'(accepted * 8);
         end
      end
      reqValid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("rst_mid_cycle", cyc, firstAcc + 5);
      chk("rst_mid_cmds_seen", cmdQ.size(), 2);
      if (cmdQ.size() == 2) chk("rst_mid_last_cmd", cmdQ[1].typ, CMD_ACT);
      chk("rst_mid_busy", busy, 1);
      rstN = 1'b0;
      #1;
      checkResetValues("rst_mid");
      cmdQ.delete();
      doneQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("rst_mid_no_done", doneQ.size(), 0);
      chk("rst_mid_no_cmds", cmdQ.size(), 0);
      chk("rst_mid_idle", busy, 0);

      // Bank 1 previously held row 0x20 open; after reset it must be closed
      waitIdle();
      cmdQ.delete();
      doneQ.delete();
      applyStimulus(vecs[8].op, vecs[8].addr, acc);
      checkOutput(vecs[8], acc, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_cmd_scheduler.md
Name: mem_cmd_scheduler

Overview:
- Accepts parsed trace requests (read, write, instruction fetch) into a request FIFO.
- Serves them strictly in order against a single-rank DRAM model with an open-page policy.
- Sequences PRE/ACT/RD/WR commands under tRCD/tCL/tRP/burst timing and reports completion per request.
- Sits between the trace-parsing front end and the DRAM command output/logging stage.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH, 8, request FIFO entries (power of 2, >=2).
- COL_LSB, 3, LSB of the column field. COL_W, 7, column width, so col = addr[9:3].
- BANK_LSB, 10, LSB of the bank field. BANK_W, 2, bank width, so bank = addr[11:10].
- ROW_LSB, 12, LSB of the row field. Row = addr[ADDR_W-1:ROW_LSB], ROW_W = ADDR_W-ROW_LSB.
- T_RCD, 3, ACT-to-RD/WR cycles (>=1).
- T_RP, 3, PRE-to-ACT cycles (>=1).
- T_CL, 4, RD/WR-to-data cycles (>=1).
- T_BURST, 2, data burst cycles (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_op  in  2  0=read, 1=write, 2=ifetch, 3=reserved (treated as read).
- req_addr  in  ADDR_W  byte address.
- cmd_valid  out  1  one-cycle command strobe.
- cmd_type  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
- cmd_bank  out  BANK_W  target bank.
- cmd_row  out  ROW_W  row (meaningful for ACT).
- cmd_col  out  COL_W  column (meaningful for RD/WR).
- done_valid  out  1  one-cycle completion pulse.
- done_op  out  2  op of the completed request.
- done_addr  out  ADDR_W  address of the completed request.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empties, FSM goes to IDLE, all banks are marked closed.
  - Outputs: cmd_valid=0, cmd_type=0, cmd_bank/row/col=0, done_valid=0, done_op=0, done_addr=0, busy=0, req_ready=1.
- Reset mid-operation abandons the in-flight request. No done_valid is ever issued for it.
- FIFO:
  - Push on req_valid&&req_ready.
  - When full, req_ready=0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- Per-bank state: open flag plus open-row register.
- FSM states: IDLE, PRE, PRE_W, ACT, ACT_W, RW, RW_W.
- IDLE: if the FIFO is non-empty, pop the head into the current-request register and go to:
  - RW if the bank is open and the row matches (hit);
  - PRE if the bank is open and the row differs (conflict);
  - ACT if the bank is closed.
- PRE/ACT/RW each last exactly one cycle, with cmd_valid=1 and the matching cmd_type/bank/row/col.
  - RW issues WR for op=1, RD otherwise.
  - cmd_valid=0 and cmd_type=NOP in all other states.
- PRE at cycle t: bank marked closed; PRE_W holds T_RP-1 cycles; ACT at t+T_RP.
- ACT at t: bank marked open with the row; ACT_W holds T_RCD-1 cycles; RW at t+T_RCD.
- RW at t: RW_W holds T_CL+T_BURST-1 cycles.
  - done_valid pulses in the last RW_W cycle (t+T_CL+T_BURST-1), with done_op/done_addr of the current request.
  - FSM is back in IDLE at t+T_CL+T_BURST.
- A wait of zero extra cycles (parameter = 1) skips the _W state.
- Latency on an empty FIFO and closed bank: request accepted at edge k; ACT cmd_valid is high in the cycle after edge k+1.
- Next request's first command is never earlier than one cycle after the IDLE re-entry cycle.
- Rows stay open after RW (no auto-precharge). No refresh.
- Requests arriving during service queue up. Order is strict FIFO with no reordering.

Test Plan:
- Reset, then read at addr 0x0001_0400 -> ACT bank1 row 0x10 at cycle t; RD bank1 col 0 at t+3; done_valid (op 0, addr 0x0001_0400) at t+8; busy drops at t+9 with an empty FIFO.
- Then write to 0x0001_0408 (same row) -> no ACT; WR bank1 col 1 only; done_valid 5 cycles after WR with done_op=1.
- Then read 0x0002_0400 (bank1 row conflict) -> PRE bank1 at t; ACT row 0x20 at t+3; RD at t+6; done at t+11.
- Hold req_valid for 12 back-to-back reads -> req_ready falls after 9 accepts (8 queued + 1 popped into service); all 12 complete in order with matching done_addr; no request is lost or duplicated.
- Assert rst_n low during ACT_W of a request with 3 more queued -> outputs return to reset values immediately; no done_valid; after release, a new read to bank1 issues ACT (bank closed), not RD.
- Reads to banks 0..3, then a second read to bank 2 with the same row -> each first access issues ACT; the repeat to bank 2 issues RD directly (per-bank open-row tracking).
